// File: rtl/gp_regfile_sb.sv
// General-purpose register file with three combinational read ports,
// same-cycle write forwarding, a per-register in-flight write scoreboard
// that raises STALL on read-after-write and saturation hazards, and a
// separately loaded flags register.
module gp_regfile_sb #(
  parameter int WIDTH        = 8,
  parameter int NUM_REGS     = 4,
  parameter int SEL_W        = 2,
  parameter int MAX_INFLIGHT = 3,
  parameter int FLAGS_W      = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                WE,
  input  logic [SEL_W-1:0]    WSEL,
  input  logic [WIDTH-1:0]    WDATA,
  input  logic [SEL_W-1:0]    LHS_SEL,
  input  logic [SEL_W-1:0]    RHS_SEL,
  input  logic [SEL_W-1:0]    MAIN_SEL,
  output logic [WIDTH-1:0]    LHS_OUT,
  output logic [WIDTH-1:0]    RHS_OUT,
  output logic [WIDTH-1:0]    MAIN_OUT,
  input  logic                ISSUE,
  input  logic                ISSUE_LHS_EN,
  input  logic                ISSUE_RHS_EN,
  input  logic                ISSUE_DEST_EN,
  input  logic [SEL_W-1:0]    ISSUE_DEST,
  output logic                STALL,
  output logic [NUM_REGS-1:0] BUSY,
  input  logic                FLAGS_LOAD,
  input  logic [FLAGS_W-1:0]  FLAGS_IN,
  output logic [FLAGS_W-1:0]  FLAGS_OUT
);

  localparam int PEND_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_INFLIGHT);
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [NUM_REGS-1:0][WIDTH-1:0]  regs;
  logic [NUM_REGS-1:0][PEND_W-1:0] pend;
  logic [NUM_REGS-1:0]             inc;
  logic [NUM_REGS-1:0]             dec;
  logic                            lhs_haz;
  logic                            rhs_haz;
  logic                            dest_sat;

  // Read-port mux: out-of-range selects read as zero; a write to the same
  // register in this cycle is forwarded ahead of the stored value.
  function automatic logic [WIDTH-1:0] rd_port(
    input logic [SEL_W-1:0]               sel,
    input logic [NUM_REGS-1:0][WIDTH-1:0] rf,
    input logic                           we,
    input logic [SEL_W-1:0]               wsel,
    input logic [WIDTH-1:0]               wdata
  );
    logic [WIDTH-1:0] val;
    val = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (sel == SEL_W'(r)) begin
        val = (we && (wsel == sel)) ? wdata : rf[r];
      end
    end
    return val;
  endfunction

  // Source hazard: the register still has writes outstanding, unless the
  // only outstanding write is being written back (and forwarded) right now.
  function automatic logic src_hazard(
    input logic                            en,
    input logic [SEL_W-1:0]                sel,
    input logic [NUM_REGS-1:0][PEND_W-1:0] pd,
    input logic                            we,
    input logic [SEL_W-1:0]                wsel
  );
    logic haz;
    haz = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (en && (sel == SEL_W'(r)) && (pd[r] != '0) &&
          !((pd[r] == PEND_ONE) && we && (wsel == sel))) begin
        haz = 1'b1;
      end
    end
    return haz;
  endfunction

  // Combinational read ports.
  always_comb begin
    LHS_OUT  = rd_port(LHS_SEL,  regs, WE, WSEL, WDATA);
    RHS_OUT  = rd_port(RHS_SEL,  regs, WE, WSEL, WDATA);
    MAIN_OUT = rd_port(MAIN_SEL, regs, WE, WSEL, WDATA);
  end

  // Hazard detection and scoreboard increment/decrement strobes. STALL is
  // built only from pend, the issue request and the write-back, so inc can
  // depend on STALL without forming a loop.
  always_comb begin
    dec      = '0;
    inc      = '0;
    dest_sat = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      dec[r] = WE && (WSEL == SEL_W'(r)) && (pend[r] != '0);
    end
    for (int r = 0; r < NUM_REGS; r++) begin
      if (ISSUE_DEST_EN && (ISSUE_DEST == SEL_W'(r)) &&
          (pend[r] == PEND_MAX) && !dec[r]) begin
        dest_sat = 1'b1;
      end
    end
    lhs_haz = src_hazard(ISSUE_LHS_EN, LHS_SEL, pend, WE, WSEL);
    rhs_haz = src_hazard(ISSUE_RHS_EN, RHS_SEL, pend, WE, WSEL);
    STALL   = ISSUE && (lhs_haz || rhs_haz || dest_sat);
    for (int r = 0; r < NUM_REGS; r++) begin
      inc[r] = ISSUE && !STALL && ISSUE_DEST_EN && (ISSUE_DEST == SEL_W'(r));
    end
  end

  // Busy vector mirrors non-zero pending counters.
  always_comb begin
    BUSY = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      BUSY[r] = (pend[r] != '0);
    end
  end

  // Register storage: write-back to in-range selects only.
  always_ff @(posedge CLK) begin
    if (RST) begin
      regs <= '0;
    end else if (WE) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (WSEL == SEL_W'(r)) begin
          regs[r] <= WDATA;
        end
      end
    end
  end

  // Scoreboard counters: simultaneous issue and write-back cancel out.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pend <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (inc[r] && !dec[r]) begin
          pend[r] <= pend[r] + PEND_ONE;
        end else if (!inc[r] && dec[r]) begin
          pend[r] <= pend[r] - PEND_ONE;
        end
      end
    end
  end

  // Flags register: load-enabled, no forwarding.
  always_ff @(posedge CLK) begin
    if (RST) begin
      FLAGS_OUT <= '0;
    end else if (FLAGS_LOAD) begin
      FLAGS_OUT <= FLAGS_IN;
    end
  end

endmodule

// File: tb/tb_gp_regfile_sb.sv
// Directed bench for gp_regfile_sb. Uses a 3-bit select with four registers
// so that out-of-range selects (e.g. 4) can be exercised.
module tb_gp_regfile_sb;

  localparam int WIDTH        = 8;
  localparam int NUM_REGS     = 4;
  localparam int SEL_W        = 3;
  localparam int MAX_INFLIGHT = 3;
  localparam int FLAGS_W      = 4;

  logic                CLK = 1'b0;
  logic                RST;
  logic                WE;
  logic [SEL_W-1:0]    WSEL;
  logic [WIDTH-1:0]    WDATA;
  logic [SEL_W-1:0]    LHS_SEL, RHS_SEL, MAIN_SEL;
  logic [WIDTH-1:0]    LHS_OUT, RHS_OUT, MAIN_OUT;
  logic                ISSUE, ISSUE_LHS_EN, ISSUE_RHS_EN, ISSUE_DEST_EN;
  logic [SEL_W-1:0]    ISSUE_DEST;
  logic                STALL;
  logic [NUM_REGS-1:0] BUSY;
  logic                FLAGS_LOAD;
  logic [FLAGS_W-1:0]  FLAGS_IN, FLAGS_OUT;

  int n_cmp = 0;
  int n_bad = 0;

  gp_regfile_sb #(
    .WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .SEL_W(SEL_W),
    .MAX_INFLIGHT(MAX_INFLIGHT), .FLAGS_W(FLAGS_W)
  ) dut (
    .CLK(CLK), .RST(RST), .WE(WE), .WSEL(WSEL), .WDATA(WDATA),
    .LHS_SEL(LHS_SEL), .RHS_SEL(RHS_SEL), .MAIN_SEL(MAIN_SEL),
    .LHS_OUT(LHS_OUT), .RHS_OUT(RHS_OUT), .MAIN_OUT(MAIN_OUT),
    .ISSUE(ISSUE), .ISSUE_LHS_EN(ISSUE_LHS_EN), .ISSUE_RHS_EN(ISSUE_RHS_EN),
    .ISSUE_DEST_EN(ISSUE_DEST_EN), .ISSUE_DEST(ISSUE_DEST),
    .STALL(STALL), .BUSY(BUSY),
    .FLAGS_LOAD(FLAGS_LOAD), .FLAGS_IN(FLAGS_IN), .FLAGS_OUT(FLAGS_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive everything inactive.
  task automatic idle();
    RST = 1'b0; WE = 1'b0; WSEL = '0; WDATA = '0;
    LHS_SEL = '0; RHS_SEL = '0; MAIN_SEL = '0;
    ISSUE = 1'b0; ISSUE_LHS_EN = 1'b0; ISSUE_RHS_EN = 1'b0;
    ISSUE_DEST_EN = 1'b0; ISSUE_DEST = '0;
    FLAGS_LOAD = 1'b0; FLAGS_IN = '0;
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 unit after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue_dest(input logic [SEL_W-1:0] d);
    ISSUE = 1'b1; ISSUE_DEST_EN = 1'b1; ISSUE_DEST = d;
  endtask

  // Read register r through MAIN with no write in flight.
  task automatic chk_reg(input string tag, input int r, input logic [WIDTH-1:0] exp);
    MAIN_SEL = SEL_W'(r);
    #1;
    chk(tag, 32'(MAIN_OUT), 32'(exp));
  endtask

  initial begin
    idle();
    #1;
    // 1. Reset then read
    RST = 1'b1;
    tick();
    RST = 1'b0;
    for (int s = 0; s <= NUM_REGS; s++) begin
      LHS_SEL = SEL_W'(s); RHS_SEL = SEL_W'(s); MAIN_SEL = SEL_W'(s);
      #1;
      chk("rst_lhs", 32'(LHS_OUT), 0);
      chk("rst_rhs", 32'(RHS_OUT), 0);
      chk("rst_main", 32'(MAIN_OUT), 0);
    end
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_flags", 32'(FLAGS_OUT), 0);
    chk("rst_stall", 32'(STALL), 0);
    ISSUE = 1'b1; ISSUE_LHS_EN = 1'b1; ISSUE_RHS_EN = 1'b1; #1;
    chk("rst_stall_issue", 32'(STALL), 0);
    idle();

    // 2. Forwarding
    WE = 1'b1; WSEL = 3'd2; WDATA = 8'h5A; LHS_SEL = 3'd2; RHS_SEL = 3'd1;
    #1;
    chk("fwd_lhs", 32'(LHS_OUT), 32'h5A);
    chk("fwd_rhs_other", 32'(RHS_OUT), 0);
    tick();
    WE = 1'b0; WDATA = 8'h00;
    #1;
    chk("stored_lhs", 32'(LHS_OUT), 32'h5A);
    idle();

    // 3. RAW hazard
    issue_dest(3'd1);
    #1;
    chk("raw_issue_ok", 32'(STALL), 0);
    tick();
    idle();
    chk("raw_busy", 32'(BUSY), 32'b0010);
    ISSUE_LHS_EN = 1'b1; LHS_SEL = 3'd1; #1;
    chk("raw_no_issue_no_stall", 32'(STALL), 0);
    ISSUE = 1'b1; #1;
    chk("raw_stall", 32'(STALL), 1);
    tick();
    chk("raw_stalled_busy", 32'(BUSY), 32'b0010);
    WE = 1'b1; WSEL = 3'd1; WDATA = 8'h33; #1;
    chk("raw_fwd_stall", 32'(STALL), 0);
    chk("raw_fwd_lhs", 32'(LHS_OUT), 32'h33);
    tick();
    idle();
    chk("raw_busy_clear", 32'(BUSY), 0);

    // 4. Saturation
    for (int i = 0; i < 3; i++) begin
      issue_dest(3'd3); #1;
      chk("sat_fill_stall", 32'(STALL), 0);
      tick();
    end
    idle();
    chk("sat_busy", 32'(BUSY), 32'b1000);
    issue_dest(3'd3); #1;
    chk("sat_stall", 32'(STALL), 1);
    tick();
    WE = 1'b1; WSEL = 3'd3; WDATA = 8'h71; #1;
    chk("sat_wb_stall", 32'(STALL), 0);
    tick();
    idle();
    // pend[3] must still be 3: two write-backs leave it busy, the third clears it.
    WE = 1'b1; WSEL = 3'd3; WDATA = 8'h72; tick();
    WDATA = 8'h73; tick();
    WE = 1'b0; #1;
    chk("sat_still_busy", 32'(BUSY), 32'b1000);
    WE = 1'b1; WDATA = 8'h77; tick();
    idle();
    chk("sat_busy_clear", 32'(BUSY), 0);
    chk_reg("sat_reg3", 3, 8'h77);

    // 5. Multi-inflight
    issue_dest(3'd0); tick();
    issue_dest(3'd0); tick();
    idle();
    chk("multi_busy", 32'(BUSY), 32'b0001);
    ISSUE = 1'b1; ISSUE_RHS_EN = 1'b1; RHS_SEL = 3'd0;
    WE = 1'b1; WSEL = 3'd0; WDATA = 8'h11; #1;
    chk("multi_stall", 32'(STALL), 1);
    tick();
    chk("multi_busy_one", 32'(BUSY), 32'b0001);
    WDATA = 8'h22; #1;
    chk("multi_last_stall", 32'(STALL), 0);
    chk("multi_last_rhs", 32'(RHS_OUT), 32'h22);
    tick();
    idle();
    chk("multi_busy_clear", 32'(BUSY), 0);

    // 6. Edge cases: out-of-range write
    WE = 1'b1; WSEL = 3'd4; WDATA = 8'hEE; LHS_SEL = 3'd4; #1;
    chk("oor_lhs", 32'(LHS_OUT), 0);
    tick();
    idle();
    chk_reg("oor_reg0", 0, 8'h22);
    chk_reg("oor_reg1", 1, 8'h33);
    chk_reg("oor_reg2", 2, 8'h5A);
    chk_reg("oor_reg3", 3, 8'h77);
    // Out-of-range sources never hazard
    ISSUE = 1'b1; ISSUE_LHS_EN = 1'b1; LHS_SEL = 3'd4; #1;
    chk("oor_src_stall", 32'(STALL), 0);
    idle();
    // Untracked write-back
    WE = 1'b1; WSEL = 3'd1; WDATA = 8'h44; tick();
    idle();
    chk("untracked_busy", 32'(BUSY), 0);
    chk_reg("untracked_reg1", 1, 8'h44);
    // Flags
    FLAGS_LOAD = 1'b1; FLAGS_IN = 4'b1010; #1;
    chk("flags_no_fwd", 32'(FLAGS_OUT), 0);
    tick();
    chk("flags_load", 32'(FLAGS_OUT), 32'b1010);
    FLAGS_LOAD = 1'b0; FLAGS_IN = 4'b0101; tick();
    chk("flags_hold", 32'(FLAGS_OUT), 32'b1010);
    // Reset mid-operation discards the scoreboard and ignores same-cycle writes
    idle();
    issue_dest(3'd2); tick();
    idle();
    chk("mid_busy", 32'(BUSY), 32'b0100);
    RST = 1'b1; WE = 1'b1; WSEL = 3'd2; WDATA = 8'hFF;
    issue_dest(3'd1); FLAGS_LOAD = 1'b1; FLAGS_IN = 4'b1111;
    tick();
    idle();
    chk("rst_we_busy", 32'(BUSY), 0);
    chk("rst_we_flags", 32'(FLAGS_OUT), 0);
    chk_reg("rst_we_reg2", 2, 8'h00);
    chk_reg("rst_we_reg1", 1, 8'h00);
    // Write-back after reset still lands
    WE = 1'b1; WSEL = 3'd2; WDATA = 8'hC3; tick();
    idle();
    chk_reg("post_rst_wb", 2, 8'hC3);
    chk("post_rst_busy", 32'(BUSY), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
